brownout_ctl: RTL and testbench

Host-side controller for the brownout detector. Runs on the system clock and drives the detector's enable, trip-code and force controls. Receives the detector's asynchronous power-good output, synchronizes it and tracks state through a settle/monitor FSM. Provides sticky status, a saturating event counter and an interrupt to firmware.

---
 rtl/brownout_ctl.sv | 185 ++++++++++++++++++
 tb/tb_brownout_ctl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brownout_ctl.sv
// brownout_ctl: host-side brownout detector controller with settle/monitor FSM.
// Define BROWNOUT_CTL_DEGLITCH_EN to require 4 consecutive samples per transition.
module brownout_ctl #(
    parameter int SETTLE_CYCLES = 64,
    parameter int CNT_W         = 8
) (
    input  logic             ck,
    input  logic             rsb,
    input  logic             cfg_en,
    input  logic [2:0]       cfg_vtrip,
    input  logic [2:0]       cfg_otrip,
    input  logic             cfg_force_rc_osc,
    input  logic             cfg_force_short,
    input  logic             cfg_irq_en,
    input  logic             clr_status,
    input  logic             bod_good,
    output logic             bod_ena,
    output logic [2:0]       bod_vtrip,
    output logic [2:0]       bod_otrip,
    output logic             bod_force_rc_osc,
    output logic             bod_force_short_oneshot,
    output logic             status_brownout,
    output logic [CNT_W-1:0] event_cnt,
    output logic             irq,
    output logic [1:0]       fsm_state
);

    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MONITOR = 2'd2,
        ST_BROWN   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic              ena_q, ena_d;
    logic [2:0]        vtrip_q, vtrip_d;
    logic [2:0]        otrip_q, otrip_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic              frc_q, fsh_q;
    logic              status_q, status_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              irq_q;
    logic              good_s;
    logic              reload;
    logic              event_w;
`ifdef BROWNOUT_CTL_DEGLITCH_EN
    logic [1:0]        run_q, run_d;
`endif

    assign good_s = sync2_q;
    assign reload = (cfg_vtrip != vtrip_q) || (cfg_otrip != otrip_q);

    always_comb begin
        state_d  = state_q;
        ena_d    = ena_q;
        vtrip_d  = vtrip_q;
        otrip_d  = otrip_q;
        settle_d = settle_q;
        event_w  = 1'b0;
`ifdef BROWNOUT_CTL_DEGLITCH_EN
        run_d    = 2'd0;
`endif
        if (!cfg_en) begin
            state_d = ST_OFF;
            ena_d   = 1'b0;
        end else if (state_q == ST_OFF || reload) begin
            state_d  = ST_SETTLE;
            ena_d    = 1'b1;
            vtrip_d  = cfg_vtrip;
            otrip_d  = cfg_otrip;
            settle_d = SETTLE_LOAD;
        end else begin
            unique case (state_q)
                ST_OFF: ;
                ST_SETTLE: begin
                    if (settle_q == '0)
                        state_d = good_s ? ST_MONITOR : ST_BROWN;
                    else
                        settle_d = settle_q - 1'b1;
                end
`ifdef BROWNOUT_CTL_DEGLITCH_EN
                // run_q counts prior consecutive contrary samples
                ST_MONITOR: begin
                    if (!good_s) begin
                        if (run_q == 2'd3) begin
                            state_d = ST_BROWN;
                            event_w = 1'b1;
                        end else begin
                            run_d = run_q + 2'd1;
                        end
                    end
                end
                ST_BROWN: begin
                    if (good_s) begin
                        if (run_q == 2'd3)
                            state_d = ST_MONITOR;
                        else
                            run_d = run_q + 2'd1;
                    end
                end
`else
                ST_MONITOR: begin
                    if (!good_s) begin
                        state_d = ST_BROWN;
                        event_w = 1'b1;
                    end
                end
                ST_BROWN: begin
                    if (good_s)
                        state_d = ST_MONITOR;
                end
`endif
                default: ;
            endcase
        end
    end

    // A same-edge event overrides a clear, leaving a count of one
    always_comb begin
        status_d = status_q;
        cnt_d    = cnt_q;
        if (event_w) begin
            status_d = 1'b1;
            if (clr_status)
                cnt_d = CNT_W'(1);
            else if (!(&cnt_q))
                cnt_d = cnt_q + 1'b1;
        end else if (clr_status) begin
            status_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge ck or negedge rsb) begin
        if (!rsb) begin
            state_q  <= ST_OFF;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            ena_q    <= 1'b0;
            vtrip_q  <= '0;
            otrip_q  <= '0;
            settle_q <= '0;
            frc_q    <= 1'b0;
            fsh_q    <= 1'b0;
            status_q <= 1'b0;
            cnt_q    <= '0;
            irq_q    <= 1'b0;
`ifdef BROWNOUT_CTL_DEGLITCH_EN
            run_q    <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            sync1_q  <= bod_good;
            sync2_q  <= sync1_q;
            ena_q    <= ena_d;
            vtrip_q  <= vtrip_d;
            otrip_q  <= otrip_d;
            settle_q <= settle_d;
            frc_q    <= cfg_force_rc_osc;
            fsh_q    <= cfg_force_short;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            irq_q    <= status_q & cfg_irq_en;
`ifdef BROWNOUT_CTL_DEGLITCH_EN
            run_q    <= run_d;
`endif
        end
    end

    assign bod_ena                 = ena_q;
    assign bod_vtrip               = vtrip_q;
    assign bod_otrip               = otrip_q;
    assign bod_force_rc_osc        = frc_q;
    assign bod_force_short_oneshot = fsh_q;
    assign status_brownout         = status_q;
    assign event_cnt               = cnt_q;
    assign irq                     = irq_q;
    assign fsm_state               = state_q;

endmodule

// File: tb/tb_brownout_ctl.sv
// tb_brownout_ctl: directed plus randomized checks of brownout_ctl
// against a behavioural model kept in the bench.
`timescale 1ns/1ps
module tb_brownout_ctl;

    localparam int SC   = 64;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;
`ifdef BROWNOUT_CTL_DEGLITCH_EN
    localparam int NEED = 4;
`else
    localparam int NEED = 1;
`endif
    localparam int EV = NEED + 2;

    logic          ck = 1'b0;
    logic          rsb = 1'b1;
    logic          cfg_en = 1'b0;
    logic [2:0]    cfg_vtrip = 3'd0;
    logic [2:0]    cfg_otrip = 3'd0;
    logic          cfg_force_rc_osc = 1'b0;
    logic          cfg_force_short = 1'b0;
    logic          cfg_irq_en = 1'b0;
    logic          clr_status = 1'b0;
    logic          bod_good = 1'b1;
    logic          bod_ena;
    logic [2:0]    bod_vtrip;
    logic [2:0]    bod_otrip;
    logic          bod_force_rc_osc;
    logic          bod_force_short_oneshot;
    logic          status_brownout;
    logic [CW-1:0] event_cnt;
    logic          irq;
    logic [1:0]    fsm_state;

    always #5 ck = ~ck;

    brownout_ctl #(.SETTLE_CYCLES(SC), .CNT_W(CW)) dut (
        .ck(ck), .rsb(rsb),
        .cfg_en(cfg_en), .cfg_vtrip(cfg_vtrip), .cfg_otrip(cfg_otrip),
        .cfg_force_rc_osc(cfg_force_rc_osc),
        .cfg_force_short(cfg_force_short),
        .cfg_irq_en(cfg_irq_en), .clr_status(clr_status),
        .bod_good(bod_good), .bod_ena(bod_ena),
        .bod_vtrip(bod_vtrip), .bod_otrip(bod_otrip),
        .bod_force_rc_osc(bod_force_rc_osc),
        .bod_force_short_oneshot(bod_force_short_oneshot),
        .status_brownout(status_brownout), .event_cnt(event_cnt),
        .irq(irq), .fsm_state(fsm_state)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: state as 0..3, settle timed by an absolute edge deadline,
    // debounce as a history of samples seen in the current state.
    int       m_st = 0, m_cnt = 0, m_edge = 0, m_dead = 0;
    bit       m_ena = 0, m_status = 0, m_irq = 0, m_frc = 0, m_fsh = 0;
    bit       m_g1 = 0, m_gs = 0;
    bit [2:0] m_vt = 0, m_ot = 0;
    bit       m_hist[$];

    function automatic bit run_of(bit v);
        if (m_hist.size() < NEED) return 1'b0;
        for (int i = m_hist.size() - NEED; i < m_hist.size(); i++)
            if (m_hist[i] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_dead = 0;
        m_ena = 0; m_status = 0; m_irq = 0; m_frc = 0; m_fsh = 0;
        m_g1 = 0; m_gs = 0; m_vt = 0; m_ot = 0;
        m_hist.delete();
    endtask

    task automatic model_step();
        bit ev;
        int nst;
        if (!rsb) begin
            model_reset();
            return;
        end
        m_edge++;
        ev  = 0;
        nst = m_st;
        if (!cfg_en) begin
            nst = 0; m_ena = 0; m_hist.delete();
        end else if (m_st == 0 || cfg_vtrip != m_vt || cfg_otrip != m_ot) begin
            nst = 1; m_ena = 1; m_vt = cfg_vtrip; m_ot = cfg_otrip;
            m_dead = m_edge + SC;
            m_hist.delete();
        end else if (m_st == 1) begin
            if (m_edge == m_dead) nst = m_gs ? 2 : 3;
        end else if (m_st == 2) begin
            m_hist.push_back(m_gs);
            if (run_of(1'b0)) begin
                nst = 3; ev = 1; m_hist.delete();
            end
        end else begin
            m_hist.push_back(m_gs);
            if (run_of(1'b1)) begin
                nst = 2; m_hist.delete();
            end
        end
        m_irq = m_status & cfg_irq_en;
        if (ev) begin
            m_status = 1;
            m_cnt = clr_status ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
        end else if (clr_status) begin
            m_status = 0; m_cnt = 0;
        end
        m_frc = cfg_force_rc_osc;
        m_fsh = cfg_force_short;
        m_st  = nst;
        m_gs  = m_g1;
        m_g1  = bod_good;
    endtask

    always @(negedge ck) begin
        vectors++;
        if (fsm_state !== 2'(m_st) || bod_ena !== m_ena ||
            bod_vtrip !== m_vt || bod_otrip !== m_ot ||
            bod_force_rc_osc !== m_frc || bod_force_short_oneshot !== m_fsh ||
            status_brownout !== m_status || event_cnt !== CW'(m_cnt) ||
            irq !== m_irq) begin
            miscompares++;
            $display("FAIL cycle t=%0t st=%0d/%0d ena=%b/%b vt=%0d/%0d ot=%0d/%0d frc=%b/%b fsh=%b/%b sts=%b/%b cnt=%0d/%0d irq=%b/%b",
                     $time, fsm_state, m_st, bod_ena, m_ena, bod_vtrip, m_vt,
                     bod_otrip, m_ot, bod_force_rc_osc, m_frc,
                     bod_force_short_oneshot, m_fsh, status_brownout, m_status,
                     event_cnt, m_cnt, irq, m_irq);
        end
    end

    task automatic check(string nm, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge ck);
            model_step();
            @(negedge ck);
        end
    endtask

    initial begin
        #1 rsb = 1'b0;
        model_reset();
        @(negedge ck);
        tick(2);
        check("rst_fsm", fsm_state, 0);
        check("rst_ena", bod_ena, 0);
        check("rst_cnt", event_cnt, 0);
        check("rst_status", status_brownout, 0);
        check("rst_irq", irq, 0);
        rsb = 1'b1;
        tick(2);

        // settle entry and exit
        cfg_en = 1'b1; cfg_vtrip = 3'd5; cfg_otrip = 3'd2;
        tick(1);
        check("t1_ena", bod_ena, 1);
        check("t1_vtrip", bod_vtrip, 5);
        check("t1_otrip", bod_otrip, 2);
        check("t1_fsm_settle", fsm_state, 1);
        tick(SC - 1);
        check("t1_still_settle", fsm_state, 1);
        tick(1);
        check("t1_monitor", fsm_state, 2);
        check("t1_status", status_brownout, 0);
        check("t1_cnt", event_cnt, 0);

        // first brownout and irq
        cfg_irq_en = 1'b1; bod_good = 1'b0;
        tick(EV - 1);
        check("t2_not_yet", fsm_state, 2);
        tick(1);
        check("t2_brown", fsm_state, 3);
        check("t2_status", status_brownout, 1);
        check("t2_cnt", event_cnt, 1);
        check("t2_irq_lag", irq, 0);
        tick(1);
        check("t2_irq", irq, 1);
        bod_good = 1'b1;
        tick(EV);
        check("t2_recover", fsm_state, 2);
        check("t2_sticky", status_brownout, 1);

        // saturation then clear
        for (int i = 0; i < 259; i++) begin
            bod_good = 1'b0; tick(EV);
            bod_good = 1'b1; tick(EV);
        end
        check("t3_sat", event_cnt, 255);
        clr_status = 1'b1; tick(1); clr_status = 1'b0;
        check("t3_clr_cnt", event_cnt, 0);
        check("t3_clr_status", status_brownout, 0);
        tick(1);
        check("t3_irq_clr", irq, 0);

        // clear coincident with event
        bod_good = 1'b0;
        tick(EV - 1);
        clr_status = 1'b1; tick(1); clr_status = 1'b0;
        check("t4_status", status_brownout, 1);
        check("t4_cnt", event_cnt, 1);
        bod_good = 1'b1;
        tick(EV);

        // trip change and disable
        cfg_vtrip = 3'd3;
        tick(1);
        check("t5_resettle", fsm_state, 1);
        check("t5_vtrip", bod_vtrip, 3);
        check("t5_no_event", event_cnt, 1);
        tick(10);
        cfg_en = 1'b0;
        tick(1);
        check("t5_off", fsm_state, 0);
        check("t5_ena_off", bod_ena, 0);
        check("t5_keep_cnt", event_cnt, 1);
        cfg_en = 1'b1;
        tick(SC + 1);
        check("t5_monitor", fsm_state, 2);

        // short glitch
        clr_status = 1'b1; tick(1); clr_status = 1'b0;
        bod_good = 1'b0; tick(2);
        bod_good = 1'b1; tick(10);
        check("t6_glitch_cnt", event_cnt, (NEED == 1) ? 1 : 0);
        check("t6_fsm", fsm_state, 2);

        // randomized run
        for (int c = 0; c < 6000; c++) begin
            if (c == 3000) begin
                #1 rsb = 1'b0;
                model_reset();
                @(negedge ck);
                tick(2);
                rsb = 1'b1;
            end
            cfg_en = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 399) == 0) cfg_vtrip = 3'($urandom);
            if ($urandom_range(0, 399) == 0) cfg_otrip = 3'($urandom);
            if ($urandom_range(0, 5) == 0) bod_good = ~bod_good;
            if ($urandom_range(0, 19) == 0) cfg_irq_en = ~cfg_irq_en;
            clr_status = ($urandom_range(0, 39) == 0);
            cfg_force_rc_osc = 1'($urandom);
            cfg_force_short = 1'($urandom);
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
